// File: rtl/kalman_pkg.sv
// rtl/kalman_pkg.sv - shared Q8.8 constants, FSM states and saturation helper for the Kalman scheduler
package kalman_pkg;

    localparam int Q_W      = 16;
    localparam int FRAC     = 8;
    localparam int ONE      = 256;
    localparam int DIV_ITER = 24;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LOAD,
        ST_DIV,
        ST_UPDATE,
        ST_OUT
    } kstate_e;

    function automatic logic [Q_W-1:0] sat_u16(input logic signed [31:0] v);
        if (v < 0) begin
            return '0;
        end else if (v > 32'sd65535) begin
            return '1;
        end else begin
            return v[Q_W-1:0];
        end
    endfunction

endpackage

// File: rtl/kalman_scheduler_if.sv
// rtl/kalman_scheduler_if.sv - request/result bus between sensor front-ends and the Kalman scheduler
interface kalman_scheduler_if #(
    parameter int NCH = 4
);
    localparam int CHW = $clog2(NCH);

    logic [NCH-1:0]   req_valid;
    logic [8*NCH-1:0] req_meas;
    logic [NCH-1:0]   req_ack;
    logic             busy;
    logic             out_valid;
    logic [CHW-1:0]   out_ch;
    logic [15:0]      out_data;

    modport master (
        output req_valid, req_meas,
        input  req_ack, busy, out_valid, out_ch, out_data
    );

    modport slave (
        input  req_valid, req_meas,
        output req_ack, busy, out_valid, out_ch, out_data
    );

endinterface

// File: rtl/kalman_seq_div.sv
// rtl/kalman_seq_div.sv - 24/17-bit restoring divider, one quotient bit per cycle, with divide-by-zero flag
module kalman_seq_div
    import kalman_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic [23:0] dividend,
    input  logic [16:0] divisor,
    output logic        done,
    output logic [23:0] quotient,
    output logic        div_zero
);

    logic [16:0] rem_q, rem_d;
    logic [23:0] quo_q, quo_d;
    logic [16:0] den_q, den_d;
    logic [4:0]  cnt_q, cnt_d;
    logic        run_q, run_d;
    logic        dz_q, dz_d;
    logic [17:0] rem_sh;

    always_comb begin
        rem_d  = rem_q;
        quo_d  = quo_q;
        den_d  = den_q;
        cnt_d  = cnt_q;
        run_d  = run_q;
        dz_d   = dz_q;
        rem_sh = {rem_q, quo_q[23]};
        if (start) begin
            rem_d = '0;
            quo_d = dividend;
            den_d = divisor;
            cnt_d = '0;
            run_d = 1'b1;
            dz_d  = (divisor == '0);
        end else if (run_q) begin
            // A zero divisor still burns the full iteration count so latency is fixed.
            if (!dz_q) begin
                if (rem_sh >= {1'b0, den_q}) begin
                    rem_d = 17'(rem_sh - {1'b0, den_q});
                    quo_d = {quo_q[22:0], 1'b1};
                end else begin
                    rem_d = rem_sh[16:0];
                    quo_d = {quo_q[22:0], 1'b0};
                end
            end
            cnt_d = cnt_q + 5'd1;
            if (cnt_q == 5'(DIV_ITER - 1)) begin
                run_d = 1'b0;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            rem_q <= '0;
            quo_q <= '0;
            den_q <= '0;
            cnt_q <= '0;
            run_q <= 1'b0;
            dz_q  <= 1'b0;
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            den_q <= den_d;
            cnt_q <= cnt_d;
            run_q <= run_d;
            dz_q  <= dz_d;
        end
    end

    assign done     = run_q && (cnt_q == 5'(DIV_ITER - 1));
    assign quotient = quo_q;
    assign div_zero = dz_q;

endmodule

// File: rtl/kalman_scheduler.sv
// rtl/kalman_scheduler.sv - round-robin time-shared scalar Kalman update engine; KALMAN_SCHED_CFG_EN adds runtime R/Q config
module kalman_scheduler
    import kalman_pkg::*;
#(
    parameter int          NCH   = 4,
    parameter logic [15:0] R_DEF = 16'd10240,
    parameter logic [15:0] Q_DEF = 16'd2560
) (
    input  logic        clk,
    input  logic        rst_n,
`ifdef KALMAN_SCHED_CFG_EN
    input  logic        cfg_we,
    input  logic        cfg_sel,
    input  logic [15:0] cfg_data,
`endif
    kalman_scheduler_if.slave bus
);

    localparam int CHW = $clog2(NCH);

    kstate_e        state_q, state_d;
    logic [CHW-1:0] ptr_q, ptr_d;
    logic [CHW-1:0] ch_q, ch_d;
    logic [7:0]     meas_q, meas_d;
    logic [15:0]    p_q [NCH];
    logic [15:0]    p_d [NCH];
    logic [15:0]    uh_q [NCH];
    logic [15:0]    uh_d [NCH];
    logic [CHW-1:0] out_ch_q, out_ch_d;
    logic [15:0]    out_data_q, out_data_d;
    logic [15:0]    r_cur, q_cur;

    logic           gnt_any;
    logic [CHW-1:0] gnt_ch;
    logic [CHW:0]   cand_w;
    logic           ack;
    logic           busy;

    logic           div_done, div_zero;
    logic [23:0]    quotient;
    logic [15:0]    p_cur, uh_cur, uh_new, p_new;
    logic [8:0]     k;
    logic signed [31:0] innov, corr, uh_sum, p_sum;

    // First requester at or after the pointer, wrapping modulo NCH.
    always_comb begin
        gnt_any = 1'b0;
        gnt_ch  = '0;
        cand_w  = '0;
        for (int i = 0; i < NCH; i++) begin
            cand_w = {1'b0, ptr_q} + (CHW+1)'(i);
            if (cand_w >= (CHW+1)'(NCH)) begin
                cand_w = cand_w - (CHW+1)'(NCH);
            end
            if (!gnt_any && bus.req_valid[cand_w[CHW-1:0]]) begin
                gnt_any = 1'b1;
                gnt_ch  = cand_w[CHW-1:0];
            end
        end
    end

    assign ack  = rst_n && (state_q == ST_IDLE) && gnt_any;
    assign busy = (state_q != ST_IDLE) || ack;

    always_comb begin
        p_cur  = p_q[ch_q];
        uh_cur = uh_q[ch_q];
        if (div_zero || (quotient > 24'(ONE))) begin
            k = 9'(ONE);
        end else begin
            k = quotient[8:0];
        end
        innov  = $signed({16'd0, meas_q, 8'd0}) - $signed({16'd0, uh_cur});
        corr   = ($signed({23'd0, k}) * innov) >>> FRAC;
        uh_sum = $signed({16'd0, uh_cur}) + corr;
        p_sum  = $signed(({23'd0, 9'(ONE) - k} * {16'd0, p_cur}) >> FRAC) + $signed({16'd0, q_cur});
        uh_new = sat_u16(uh_sum);
        p_new  = sat_u16(p_sum);
    end

    kalman_seq_div u_div (
        .clk      (clk),
        .rst_n    (rst_n),
        .start    (state_q == ST_LOAD),
        .dividend ({p_cur, 8'd0}),
        .divisor  ({1'b0, p_cur} + {1'b0, r_cur}),
        .done     (div_done),
        .quotient (quotient),
        .div_zero (div_zero)
    );

    always_comb begin
        state_d    = state_q;
        ptr_d      = ptr_q;
        ch_d       = ch_q;
        meas_d     = meas_q;
        p_d        = p_q;
        uh_d       = uh_q;
        out_ch_d   = out_ch_q;
        out_data_d = out_data_q;
        case (state_q)
            ST_IDLE: begin
                if (gnt_any) begin
                    ch_d    = gnt_ch;
                    meas_d  = bus.req_meas[{gnt_ch, 3'b000} +: 8];
                    ptr_d   = (gnt_ch == CHW'(NCH - 1)) ? '0 : gnt_ch + 1'b1;
                    state_d = ST_LOAD;
                end
            end
            ST_LOAD: state_d = ST_DIV;
            ST_DIV: begin
                if (div_done) begin
                    state_d = ST_UPDATE;
                end
            end
            ST_UPDATE: begin
                p_d[ch_q]  = p_new;
                uh_d[ch_q] = uh_new;
                out_ch_d   = ch_q;
                out_data_d = uh_new;
                state_d    = ST_OUT;
            end
            ST_OUT:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            ptr_q      <= '0;
            ch_q       <= '0;
            meas_q     <= '0;
            out_ch_q   <= '0;
            out_data_q <= '0;
            for (int i = 0; i < NCH; i++) begin
                p_q[i]  <= '0;
                uh_q[i] <= '0;
            end
        end else begin
            state_q    <= state_d;
            ptr_q      <= ptr_d;
            ch_q       <= ch_d;
            meas_q     <= meas_d;
            out_ch_q   <= out_ch_d;
            out_data_q <= out_data_d;
            p_q        <= p_d;
            uh_q       <= uh_d;
        end
    end

`ifdef KALMAN_SCHED_CFG_EN
    logic [15:0] r_q, r_d, q_q, q_d, pr_q, pr_d, pq_q, pq_d;
    logic        pr_v_q, pr_v_d, pq_v_q, pq_v_d;

    // Writes during a sequence are parked and land as the FSM leaves OUT.
    always_comb begin
        r_d    = r_q;
        q_d    = q_q;
        pr_d   = pr_q;
        pq_d   = pq_q;
        pr_v_d = pr_v_q;
        pq_v_d = pq_v_q;
        if (cfg_we) begin
            if (busy) begin
                if (cfg_sel) begin
                    pq_d   = cfg_data;
                    pq_v_d = 1'b1;
                end else begin
                    pr_d   = cfg_data;
                    pr_v_d = 1'b1;
                end
            end else if (cfg_sel) begin
                q_d = cfg_data;
            end else begin
                r_d = cfg_data;
            end
        end
        if (state_q == ST_OUT) begin
            if (pr_v_d) begin
                r_d = pr_d;
            end
            if (pq_v_d) begin
                q_d = pq_d;
            end
            pr_v_d = 1'b0;
            pq_v_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_q    <= R_DEF;
            q_q    <= Q_DEF;
            pr_q   <= '0;
            pq_q   <= '0;
            pr_v_q <= 1'b0;
            pq_v_q <= 1'b0;
        end else begin
            r_q    <= r_d;
            q_q    <= q_d;
            pr_q   <= pr_d;
            pq_q   <= pq_d;
            pr_v_q <= pr_v_d;
            pq_v_q <= pq_v_d;
        end
    end

    assign r_cur = r_q;
    assign q_cur = q_q;
`else
    assign r_cur = R_DEF;
    assign q_cur = Q_DEF;
`endif

    assign bus.req_ack   = ack ? ({{(NCH-1){1'b0}}, 1'b1} << gnt_ch) : '0;
    assign bus.busy      = busy;
    assign bus.out_valid = (state_q == ST_OUT);
    assign bus.out_ch    = out_ch_q;
    assign bus.out_data  = out_data_q;

endmodule

// File: tb/tb_kalman_scheduler.sv
// tb/tb_kalman_scheduler.sv - randomized self-checking bench for kalman_scheduler against a per-update arithmetic model
module tb_kalman_scheduler;

    localparam int NCH   = 4;
    localparam int R_DEF = 10240;
    localparam int Q_DEF = 2560;
    localparam int LAT   = 27;

    logic clk = 1'b0;
    logic rst_n;
`ifdef KALMAN_SCHED_CFG_EN
    logic        cfg_we = 1'b0;
    logic        cfg_sel = 1'b0;
    logic [15:0] cfg_data = '0;
`endif

    kalman_scheduler_if #(.NCH(NCH)) bus ();

    kalman_scheduler #(.NCH(NCH)) dut (
        .clk      (clk),
        .rst_n    (rst_n),
`ifdef KALMAN_SCHED_CFG_EN
        .cfg_we   (cfg_we),
        .cfg_sel  (cfg_sel),
        .cfg_data (cfg_data),
`endif
        .bus      (bus)
    );

    always #5 clk = ~clk;

    int n_chk = 0;
    int n_err = 0;
    int cyc = 0;
    int m_p [NCH];
    int m_uh [NCH];
    int m_ptr, m_r, m_q;
    bit seq_active;
    int seq_start, exp_ch, exp_data, hold_ch, hold_data;
    int last_obs_data;
    bit pend_r_v, pend_q_v;
    int pend_r, pend_q;
    logic [NCH-1:0] last_ack;
    int ack_log_ch[$];
    int ack_log_cyc[$];

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at cycle %0d", tag, got, got, exp, exp, cyc);
        end
    endtask

    function automatic int rr_pick(input logic [NCH-1:0] v, input int ptr);
        for (int i = 0; i < NCH; i++) begin
            if (v[(ptr + i) % NCH]) return (ptr + i) % NCH;
        end
        return -1;
    endfunction

    // One scalar Kalman step in plain integer arithmetic.
    task automatic model_update(input int ch, input int meas, output int res);
        int p, uh, k, innov, uhn, pn;
        p  = m_p[ch];
        uh = m_uh[ch];
        if (p + m_r == 0) k = 256;
        else begin
            k = (p * 256) / (p + m_r);
            if (k > 256) k = 256;
        end
        innov = meas * 256 - uh;
        uhn   = uh + ((k * innov) >>> 8);
        if (uhn < 0) uhn = 0;
        if (uhn > 65535) uhn = 65535;
        pn = (((256 - k) * p) >> 8) + m_q;
        if (pn > 65535) pn = 65535;
        m_p[ch]  = pn;
        m_uh[ch] = uhn;
        res = uhn;
    endtask

    task automatic model_reset();
        for (int i = 0; i < NCH; i++) begin
            m_p[i]  = 0;
            m_uh[i] = 0;
        end
        m_ptr = 0; seq_active = 0; hold_ch = 0; hold_data = 0;
        m_r = R_DEF; m_q = Q_DEF; pend_r_v = 0; pend_q_v = 0;
    endtask

    task automatic mon_cycle();
        int pick, meas;
        logic [NCH-1:0] exp_ack;
        bit out_now;
        if (seq_active && (cyc - seq_start > LAT)) seq_active = 0;
        exp_ack = '0;
        pick = -1;
        if (!seq_active) begin
            pick = rr_pick(bus.req_valid, m_ptr);
            if (pick >= 0) exp_ack[pick] = 1'b1;
        end
        check_eq("req_ack", 32'(bus.req_ack), 32'(exp_ack));
        if (pick >= 0) begin
            meas = int'(bus.req_meas[8*pick +: 8]);
            exp_ch = pick;
            model_update(pick, meas, exp_data);
            m_ptr = (pick + 1) % NCH;
            seq_active = 1;
            seq_start = cyc;
            ack_log_ch.push_back(pick);
            ack_log_cyc.push_back(cyc);
        end
`ifdef KALMAN_SCHED_CFG_EN
        if (cfg_we) begin
            if (seq_active) begin
                if (cfg_sel) begin pend_q = int'(cfg_data); pend_q_v = 1; end
                else begin pend_r = int'(cfg_data); pend_r_v = 1; end
            end else if (cfg_sel) m_q = int'(cfg_data);
            else m_r = int'(cfg_data);
        end
`endif
        check_eq("busy", 32'(bus.busy), 32'(seq_active));
        out_now = seq_active && (cyc - seq_start == LAT);
        check_eq("out_valid", 32'(bus.out_valid), 32'(out_now));
        if (out_now) begin
            hold_ch = exp_ch;
            hold_data = exp_data;
            last_obs_data = int'(bus.out_data);
            if (pend_r_v) m_r = pend_r;
            if (pend_q_v) m_q = pend_q;
            pend_r_v = 0;
            pend_q_v = 0;
        end
        check_eq("out_ch", 32'(bus.out_ch), 32'(hold_ch));
        check_eq("out_data", 32'(bus.out_data), 32'(hold_data));
    endtask

    always @(negedge clk) begin
        cyc++;
        last_ack = bus.req_ack;
        if (!rst_n) model_reset();
        else mon_cycle();
    end

    task automatic tick();
        @(posedge clk);
        #1;
        bus.req_valid = bus.req_valid & ~last_ack;
    endtask

    task automatic do_req(input int ch, input int meas);
        int n = 0;
        bus.req_meas[8*ch +: 8] = 8'(meas);
        bus.req_valid[ch] = 1'b1;
        while (bus.req_valid[ch] && n < 400) begin
            tick();
            n++;
        end
        check_eq("ack_seen", 32'(bus.req_valid[ch]), 32'd0);
        bus.req_valid[ch] = 1'b0;
    endtask

    task automatic wait_done();
        int n = 0;
        while ((seq_active || bus.busy) && n < 100) begin
            tick();
            n++;
        end
        check_eq("seq_done", 32'(bus.busy), 32'd0);
    endtask

    task automatic do_reset(input int cycles);
        rst_n = 1'b0;
        repeat (cycles) tick();
        rst_n = 1'b1;
    endtask

    initial begin
        rst_n = 1'b0;
        bus.req_valid = '0;
        bus.req_meas  = '0;
        model_reset();
        do_reset(3);
        check_eq("rst_busy", 32'(bus.busy), 0);
        check_eq("rst_ack", 32'(bus.req_ack), 0);
        check_eq("rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("rst_out_ch", 32'(bus.out_ch), 0);
        check_eq("rst_out_data", 32'(bus.out_data), 0);

        do_req(0, 100);
        wait_done();
        check_eq("first_out", 32'(last_obs_data), 0);
        check_eq("p0_first", 32'(dut.p_q[0]), 2560);
        do_req(0, 100);
        wait_done();
        check_eq("second_out", 32'(last_obs_data), 32'h13EC);
        check_eq("p0_second", 32'(dut.p_q[0]), 4610);
        check_eq("p1_iso", 32'(dut.p_q[1]), 0);
        check_eq("uh1_iso", 32'(dut.uh_q[1]), 0);

        // All channels requesting straight out of reset.
        rst_n = 1'b0;
        for (int ch = 0; ch < NCH; ch++) bus.req_meas[8*ch +: 8] = 8'($urandom);
        bus.req_valid = '1;
        tick();
        tick();
        rst_n = 1'b1;
        ack_log_ch.delete();
        ack_log_cyc.delete();
        for (int c = 0; c < 5 * 28 + 5; c++) begin
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                if (!bus.req_valid[ch]) begin
                    bus.req_meas[8*ch +: 8] = 8'($urandom);
                    bus.req_valid[ch] = 1'b1;
                end
            end
        end
        bus.req_valid = '0;
        check_eq("rr_count", 32'(ack_log_ch.size() >= 5), 1);
        for (int i = 0; i < 5 && i < ack_log_ch.size(); i++) begin
            check_eq("rr_order", 32'(ack_log_ch[i]), 32'(i % NCH));
            if (i > 0) check_eq("rr_spacing", 32'(ack_log_cyc[i] - ack_log_cyc[i-1]), 28);
        end
        wait_done();

        for (int i = 0; i < 25; i++) begin
            do_req(2, 255);
            wait_done();
        end
        check_eq("clamp_high", 32'(last_obs_data), 32'(m_uh[2]));
        check_eq("clamp_high_range", 32'(last_obs_data <= 32'hFF00 && last_obs_data >= 32'hF000), 1);
        for (int i = 0; i < 25; i++) begin
            do_req(2, 0);
            wait_done();
        end
        check_eq("clamp_low", 32'(last_obs_data), 32'(m_uh[2]));
        for (int i = 0; i < 4; i++) begin
            do_req(2, 255);
            wait_done();
        end

        for (int c = 0; c < 600; c++) begin
            tick();
            for (int ch = 0; ch < NCH; ch++) begin
                if (!bus.req_valid[ch]) begin
                    if ($urandom_range(7) == 0) begin
                        bus.req_meas[8*ch +: 8] = 8'($urandom);
                        bus.req_valid[ch] = 1'b1;
                    end
                end else if ($urandom_range(63) == 0) begin
                    bus.req_valid[ch] = 1'b0;
                end
            end
        end
        bus.req_valid = '0;
        wait_done();

        do_req(1, 200);
        repeat (9) tick();
        do_reset(1);
        check_eq("mid_rst_busy", 32'(bus.busy), 0);
        check_eq("mid_rst_out_valid", 32'(bus.out_valid), 0);
        check_eq("mid_rst_out_ch", 32'(bus.out_ch), 0);
        check_eq("mid_rst_out_data", 32'(bus.out_data), 0);
        check_eq("mid_rst_p2", 32'(dut.p_q[2]), 0);
        check_eq("mid_rst_uh2", 32'(dut.uh_q[2]), 0);
        ack_log_ch.delete();
        ack_log_cyc.delete();
        bus.req_meas[8*3 +: 8] = 8'd50;
        bus.req_meas[8*0 +: 8] = 8'd60;
        bus.req_valid[3] = 1'b1;
        bus.req_valid[0] = 1'b1;
        for (int c = 0; c < 80 && bus.req_valid != '0; c++) tick();
        bus.req_valid = '0;
        check_eq("post_rst_acks", 32'(ack_log_ch.size()), 2);
        if (ack_log_ch.size() > 0) check_eq("post_rst_first", 32'(ack_log_ch[0]), 0);
        wait_done();

`ifdef KALMAN_SCHED_CFG_EN
        do_reset(1);
        do_req(0, 100);
        wait_done();
        do_req(0, 100);
        repeat (5) tick();
        cfg_we = 1'b1; cfg_sel = 1'b0; cfg_data = 16'd0;
        tick();
        cfg_we = 1'b0;
        wait_done();
        check_eq("cfg_old_r", 32'(last_obs_data), 5100);
        do_req(3, 77);
        wait_done();
        check_eq("cfg_div_zero", 32'(last_obs_data), 32'(77 << 8));
`endif

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
